// File: rtl/dmem_responder.sv
// dmem_responder: memory side of the core's load/store port.
// One request in flight at a time. The response (rvalid pulse) comes LATENCY
// cycles after the accepting edge. Accesses are byte, half or word on a
// word-organised RAM. Illegal requests (outside the window, bad size,
// misaligned) are flagged with addr_err and have no effect on the RAM.
// Optional build macro: DMEM_STATS_EN adds saturating load/store/error
// counters and a synchronous clear input.
//
// state | meaning
// IDLE  | ready for a request (ready is held low for one cycle after reset)
// WAIT  | request captured; counting down the remaining latency
// RESP  | final cycle: commit the store, build the response for the next edge
module dmem_responder #(
  parameter int                MEM_WORDS = 4096,
  parameter int                ADDR_W    = 32,
  parameter int                LATENCY   = 1,
  parameter logic [ADDR_W-1:0] BASE_ADDR = 'h0000_2000
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              req,
  input  logic              write,
  input  logic [ADDR_W-1:0] addr,
  input  logic [1:0]        n_bytes,
  input  logic [31:0]       wdata,
  output logic              ready,
  output logic              rvalid,
  output logic [31:0]       rdata,
  output logic              addr_err
`ifdef DMEM_STATS_EN
  ,
  output logic [31:0]       stat_loads,
  output logic [31:0]       stat_stores,
  output logic [31:0]       stat_errors,
  input  logic              stat_clr
`endif
);

  localparam int IDX_W = $clog2(MEM_WORDS);
  localparam logic [ADDR_W:0] WIN_BYTES = (ADDR_W+1)'(4 * MEM_WORDS);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t            state;
  logic [3:0]        cnt;

  logic              t_write;
  logic              t_err;
  logic [IDX_W-1:0]  t_idx;
  logic [1:0]        t_lane;
  logic [1:0]        t_size;
  logic [3:0]        t_be;
  logic [31:0]       t_wdata;

  logic [31:0]       mem [MEM_WORDS];

  logic [ADDR_W-1:0] offset;
  logic              in_window;
  logic              misaligned;
  logic              req_err;
  logic [1:0]        lane;
  logic [3:0]        be;
  logic [31:0]       wdata_sh;

  logic [31:0]       rd_word;
  logic [31:0]       load_data;

  // Decode the incoming request: window check, alignment, byte enables and lane-shifted data.
  always_comb begin
    offset     = addr - BASE_ADDR;
    // Both bounds are checked so that an address below the base cannot wrap into the window.
    in_window  = (addr >= BASE_ADDR) && ({1'b0, offset} < WIN_BYTES);
    lane       = addr[1:0];
    misaligned = 1'b0;
    be         = 4'b0000;
    case (n_bytes)
      2'd0: begin
        be = 4'b0001 << lane;
      end
      2'd1: begin
        misaligned = addr[0];
        be         = lane[1] ? 4'b1100 : 4'b0011;
      end
      2'd2: begin
        misaligned = |addr[1:0];
        be         = 4'b1111;
      end
      default: begin
        misaligned = 1'b0;
        be         = 4'b0000;
      end
    endcase
    req_err  = !in_window || (n_bytes == 2'd3) || misaligned;
    wdata_sh = wdata << {lane, 3'b000};
  end

  // Extract the addressed lane(s) of the captured word, right-aligned and zero-extended.
  always_comb begin
    rd_word = mem[t_idx];
    case (t_size)
      2'd0:    load_data = (rd_word >> {t_lane, 3'b000}) & 32'h0000_00FF;
      2'd1:    load_data = t_lane[1] ? {16'b0, rd_word[31:16]} : {16'b0, rd_word[15:0]};
      default: load_data = rd_word;
    endcase
  end

  // Request sequencing FSM; ready, rvalid, rdata and addr_err are registered outputs.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state    <= IDLE;
      cnt      <= 4'd0;
      ready    <= 1'b0;
      rvalid   <= 1'b0;
      rdata    <= 32'd0;
      addr_err <= 1'b0;
      t_write  <= 1'b0;
      t_err    <= 1'b0;
      t_idx    <= '0;
      t_lane   <= 2'd0;
      t_size   <= 2'd0;
      t_be     <= 4'd0;
      t_wdata  <= 32'd0;
    end else begin
      rvalid <= 1'b0;
      case (state)
        IDLE: begin
          ready <= 1'b1;
          if (req && ready) begin
            t_write <= write;
            t_err   <= req_err;
            t_idx   <= offset[IDX_W+1:2];
            t_lane  <= lane;
            t_size  <= n_bytes;
            t_be    <= be;
            t_wdata <= wdata_sh;
            cnt     <= 4'(LATENCY - 1);
            ready   <= 1'b0;
            state   <= (LATENCY == 1) ? RESP : WAIT;
          end
        end
        WAIT: begin
          cnt <= cnt - 4'd1;
          if (cnt == 4'd1) begin
            state <= RESP;
          end
        end
        RESP: begin
          rvalid   <= 1'b1;
          addr_err <= t_err;
          rdata    <= (t_err || t_write) ? 32'd0 : load_data;
          ready    <= 1'b1;
          state    <= IDLE;
        end
        default: begin
          ready <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

  // Store commit on the edge that raises rvalid; a reset before then leaves the RAM untouched.
  always_ff @(posedge clk) begin
    if (rstn && (state == RESP) && t_write && !t_err) begin
      for (int b = 0; b < 4; b++) begin
        if (t_be[b]) begin
          mem[t_idx][8*b +: 8] <= t_wdata[8*b +: 8];
        end
      end
    end
  end

`ifdef DMEM_STATS_EN
  // Saturating response counters; clear wins over a same-cycle increment.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      stat_loads  <= 32'd0;
      stat_stores <= 32'd0;
      stat_errors <= 32'd0;
    end else if (stat_clr) begin
      stat_loads  <= 32'd0;
      stat_stores <= 32'd0;
      stat_errors <= 32'd0;
    end else if (state == RESP) begin
      if (t_err) begin
        if (stat_errors != 32'hFFFF_FFFF) stat_errors <= stat_errors + 32'd1;
      end else if (t_write) begin
        if (stat_stores != 32'hFFFF_FFFF) stat_stores <= stat_stores + 32'd1;
      end else begin
        if (stat_loads != 32'hFFFF_FFFF) stat_loads <= stat_loads + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_dmem_responder.sv
// Testbench for dmem_responder: one instance at LATENCY=1 and one at LATENCY=4,
// checked against a byte-addressed reference memory kept in the bench.
module tb_dmem_responder;

  localparam logic [31:0] BASE = 32'h0000_2000;
  localparam int          WIN  = 4 * 4096;

  logic        clk;
  logic        w;
  logic [31:0] a;
  logic [1:0]  nb;
  logic [31:0] wd;

  logic        rstn1, req1, ready1, rvalid1, err1;
  logic [31:0] rdata1;
  logic        rstn4, req4, ready4, rvalid4, err4;
  logic [31:0] rdata4;

  int passed = 0;
  int total  = 0;

  logic [7:0] mm [2][WIN];

`ifdef DMEM_STATS_EN
  logic [31:0] sl1, ss1, se1, sl4, ss4, se4;
  logic        clr1, clr4;
`endif

  dmem_responder #(.LATENCY(1)) dut1 (
    .clk(clk), .rstn(rstn1), .req(req1), .write(w), .addr(a), .n_bytes(nb), .wdata(wd),
    .ready(ready1), .rvalid(rvalid1), .rdata(rdata1), .addr_err(err1)
`ifdef DMEM_STATS_EN
    , .stat_loads(sl1), .stat_stores(ss1), .stat_errors(se1), .stat_clr(clr1)
`endif
  );

  dmem_responder #(.LATENCY(4)) dut4 (
    .clk(clk), .rstn(rstn4), .req(req4), .write(w), .addr(a), .n_bytes(nb), .wdata(wd),
    .ready(ready4), .rvalid(rvalid4), .rdata(rdata4), .addr_err(err4)
`ifdef DMEM_STATS_EN
    , .stat_loads(sl4), .stat_stores(ss4), .stat_errors(se4), .stat_clr(clr4)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic get_ready(input int d);
    return (d == 1) ? ready1 : ready4;
  endfunction

  function automatic logic get_rvalid(input int d);
    return (d == 1) ? rvalid1 : rvalid4;
  endfunction

  task automatic set_req(input int d, input logic v);
    if (d == 1) req1 = v; else req4 = v;
  endtask

  // Reference: byte-addressed memory, access legal if in window, size 1/2/4 and naturally aligned.
  function automatic void model(input int d, input logic wr, input logic [31:0] adr,
                                input logic [1:0] nsz, input logic [31:0] wdt,
                                output logic [31:0] rd, output logic er);
    longint off;
    int size;
    int mi;
    off  = {32'b0, adr};
    off  = off - longint'(BASE);
    size = 1 << nsz;
    mi   = (d == 1) ? 0 : 1;
    er   = (nsz == 2'd3) || (off < 0) || (off >= WIN) || ((off % size) != 0);
    rd   = 32'd0;
    if (!er) begin
      for (int i = 0; i < size; i++) begin
        if (wr) mm[mi][off + i] = wdt[8*i +: 8];
        else    rd = rd | (32'(mm[mi][off + i]) << (8 * i));
      end
    end
  endfunction

  // Issue one request, wait for its response; returns data, error, latency and busy-cycle count.
  task automatic txn(input int d, input logic wr, input logic [31:0] adr, input logic [1:0] nsz,
                     input logic [31:0] wdt, output logic [31:0] rd, output logic er,
                     output int lat, output int busy);
    int n;
    logic got;
    @(negedge clk);
    w = wr; a = adr; nb = nsz; wd = wdt;
    set_req(d, 1'b1);
    n = 0;
    while (!get_ready(d) && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) begin
      total++;
      $display("FAIL accept_timeout: dut L=%0d ready stayed %b, required 1", d, get_ready(d));
    end
    @(posedge clk);
    lat = 0; busy = 0; got = 1'b0;
    while (!got && lat < 40) begin
      @(negedge clk);
      if (lat == 0) set_req(d, 1'b0);
      if (!get_ready(d)) busy++;
      @(posedge clk);
      lat++;
      #1;
      got = get_rvalid(d);
    end
    if (!got) begin
      total++;
      $display("FAIL rvalid_timeout: dut L=%0d rvalid %b after %0d cycles, required 1", d, got, lat);
    end
    rd = (d == 1) ? rdata1 : rdata4;
    er = (d == 1) ? err1 : err4;
  endtask

  task automatic test_reset();
    rstn1 = 1'b0; rstn4 = 1'b0; req1 = 1'b0; req4 = 1'b0;
    w = 1'b0; a = 32'd0; nb = 2'd0; wd = 32'd0;
`ifdef DMEM_STATS_EN
    clr1 = 1'b0; clr4 = 1'b0;
`endif
    repeat (3) @(negedge clk);
    total++;
    if ({ready1, rvalid1, rdata1, err1} !== 35'd0)
      $display("FAIL reset_outputs_l1: got %h, required 0", {ready1, rvalid1, rdata1, err1});
    else passed++;
    total++;
    if ({ready4, rvalid4, rdata4, err4} !== 35'd0)
      $display("FAIL reset_outputs_l4: got %h, required 0", {ready4, rvalid4, rdata4, err4});
    else passed++;
    rstn1 = 1'b1; rstn4 = 1'b1;
    #1;
    total++;
    if ({ready1, ready4} !== 2'b00) $display("FAIL ready_before_edge: got %b, required 00", {ready1, ready4});
    else passed++;
    @(posedge clk); #1;
    total++;
    if ({ready1, ready4} !== 2'b11) $display("FAIL ready_after_edge: got %b, required 11", {ready1, ready4});
    else passed++;
  endtask

  task automatic test_init();
    logic [31:0] rd, erd, v, adr;
    logic er, eer;
    int lat, busy;
    foreach (mm[i, j]) mm[i][j] = 8'h00;
    for (int di = 0; di < 2; di++) begin
      for (int k = 0; k < 68; k++) begin
        adr = (k < 64) ? (BASE + 32'(4 * k)) : (32'h5FF0 + 32'(4 * (k - 64)));
        v   = $urandom;
        txn((di == 0) ? 1 : 4, 1'b1, adr, 2'd2, v, rd, er, lat, busy);
        model((di == 0) ? 1 : 4, 1'b1, adr, 2'd2, v, erd, eer);
        total++;
        if ({er, rd} !== {eer, erd}) $display("FAIL init_store %h: got err=%b rdata=%h, required err=%b rdata=%h", adr, er, rd, eer, erd);
        else passed++;
      end
    end
  endtask

  task automatic test_word();
    logic [31:0] rd, erd;
    logic er, eer;
    int lat, busy;
    txn(1, 1'b1, 32'h2000, 2'd2, 32'hDEAD_BEEF, rd, er, lat, busy);
    model(1, 1'b1, 32'h2000, 2'd2, 32'hDEAD_BEEF, erd, eer);
    total++;
    if (lat !== 1) $display("FAIL word_store_latency: got %0d, required 1", lat); else passed++;
    total++;
    if (er !== 1'b0) $display("FAIL word_store_err: got %b, required 0", er); else passed++;
    txn(1, 1'b0, 32'h2000, 2'd2, 32'd0, rd, er, lat, busy);
    total++;
    if ({er, rd} !== {1'b0, 32'hDEAD_BEEF}) $display("FAIL word_load: got err=%b rdata=%h, required 0/deadbeef", er, rd);
    else passed++;
  endtask

  task automatic test_lanes();
    logic [31:0] rd, erd;
    logic er, eer;
    int lat, busy;
    txn(1, 1'b1, 32'h2010, 2'd2, 32'h1122_3344, rd, er, lat, busy);
    model(1, 1'b1, 32'h2010, 2'd2, 32'h1122_3344, erd, eer);
    txn(1, 1'b1, 32'h2012, 2'd0, 32'h0000_00AA, rd, er, lat, busy);
    model(1, 1'b1, 32'h2012, 2'd0, 32'h0000_00AA, erd, eer);
    total++;
    if ({er, rd} !== 33'd0) $display("FAIL byte_store_resp: got err=%b rdata=%h, required 0/0", er, rd); else passed++;
    txn(1, 1'b0, 32'h2010, 2'd2, 32'd0, rd, er, lat, busy);
    total++;
    if (rd !== 32'h11AA_3344) $display("FAIL lane_word_load: got %h, required 11aa3344", rd); else passed++;
    txn(1, 1'b0, 32'h2012, 2'd1, 32'd0, rd, er, lat, busy);
    total++;
    if (rd !== 32'h0000_11AA) $display("FAIL lane_half_load: got %h, required 000011aa", rd); else passed++;
    txn(1, 1'b0, 32'h2013, 2'd0, 32'd0, rd, er, lat, busy);
    total++;
    if (rd !== 32'h0000_0011) $display("FAIL lane_byte_load: got %h, required 00000011", rd); else passed++;
  endtask

  task automatic test_errors();
    logic [31:0] rd, erd;
    logic er, eer;
    int lat, busy;
    txn(1, 1'b0, 32'h2001, 2'd1, 32'd0, rd, er, lat, busy);
    total++;
    if ({er, rd} !== {1'b1, 32'd0}) $display("FAIL misaligned_half: got err=%b rdata=%h, required 1/0", er, rd); else passed++;
    txn(1, 1'b1, 32'h6000, 2'd2, 32'h0BAD_0BAD, rd, er, lat, busy);
    total++;
    if (er !== 1'b1) $display("FAIL out_of_window_store: got err=%b, required 1", er); else passed++;
    model(1, 1'b0, 32'h5FFC, 2'd2, 32'd0, erd, eer);
    txn(1, 1'b0, 32'h5FFC, 2'd2, 32'd0, rd, er, lat, busy);
    total++;
    if ({er, rd} !== {1'b0, erd}) $display("FAIL last_word_load: got err=%b rdata=%h, required 0/%h", er, rd, erd); else passed++;
    txn(1, 1'b0, 32'h1FFF, 2'd0, 32'd0, rd, er, lat, busy);
    total++;
    if (er !== 1'b1) $display("FAIL below_base: got err=%b, required 1", er); else passed++;
    txn(1, 1'b0, 32'h2004, 2'd3, 32'd0, rd, er, lat, busy);
    total++;
    if ({er, rd} !== {1'b1, 32'd0}) $display("FAIL size3: got err=%b rdata=%h, required 1/0", er, rd); else passed++;
  endtask

  task automatic test_latency();
    logic [31:0] rd, erd;
    logic er, eer;
    int lat, busy;
    model(4, 1'b0, 32'h2008, 2'd2, 32'd0, erd, eer);
    txn(4, 1'b0, 32'h2008, 2'd2, 32'd0, rd, er, lat, busy);
    total++;
    if (lat !== 4) $display("FAIL l4_latency: got %0d, required 4", lat); else passed++;
    total++;
    if (busy !== 4) $display("FAIL l4_busy: got %0d ready-low cycles, required 4", busy); else passed++;
    total++;
    if (rd !== erd) $display("FAIL l4_load: got %h, required %h", rd, erd); else passed++;
    @(posedge clk); #1;
    total++;
    if (rvalid4 !== 1'b0) $display("FAIL l4_pulse_width: rvalid got %b, required 0", rvalid4); else passed++;
  endtask

  task automatic test_back_to_back();
    logic [31:0] erd, rd;
    logic eer;
    int n, edges, first, second, rdy_at_resp;
    model(4, 1'b1, 32'h2040, 2'd2, 32'hCAFE_F00D, erd, eer);
    model(4, 1'b0, 32'h2040, 2'd2, 32'd0, erd, eer);
    @(negedge clk);
    w = 1'b1; a = 32'h2040; nb = 2'd2; wd = 32'hCAFE_F00D; req4 = 1'b1;
    n = 0;
    while (!ready4 && n < 50) begin @(negedge clk); n++; end
    @(posedge clk);
    @(negedge clk);
    w = 1'b0;
    edges = 0; first = 0; second = 0; rdy_at_resp = 0; rd = 32'd0;
    while (second == 0 && edges < 40) begin
      @(posedge clk); edges++; #1;
      if (rvalid4) begin
        if (first == 0) first = edges;
        else begin second = edges; rd = rdata4; end
      end
      @(negedge clk);
      if (first != 0 && edges == first) rdy_at_resp = ready4;
      if (first != 0 && edges == first + 1) req4 = 1'b0;
    end
    req4 = 1'b0;
    total++;
    if (first !== 4) $display("FAIL b2b_first: rvalid at edge %0d, required 4", first); else passed++;
    total++;
    if (rdy_at_resp !== 1) $display("FAIL b2b_ready: ready during response %0d, required 1", rdy_at_resp); else passed++;
    total++;
    if (second !== 9) $display("FAIL b2b_second: rvalid at edge %0d, required 9", second); else passed++;
    total++;
    if (rd !== erd) $display("FAIL b2b_data: got %h, required %h", rd, erd); else passed++;
    repeat (6) @(negedge clk);
  endtask

  task automatic test_reset_mid();
    logic [31:0] rd, erd, v;
    logic er, eer;
    int lat, busy, n, seen;
    v = $urandom;
    txn(4, 1'b1, 32'h2020, 2'd2, v, rd, er, lat, busy);
    model(4, 1'b1, 32'h2020, 2'd2, v, erd, eer);
    @(negedge clk);
    w = 1'b1; a = 32'h2020; nb = 2'd2; wd = 32'h5555_5555; req4 = 1'b1;
    n = 0;
    while (!ready4 && n < 50) begin @(negedge clk); n++; end
    @(posedge clk);
    seen = 0;
    @(negedge clk); req4 = 1'b0;
    @(posedge clk); #1; if (rvalid4) seen++;
    @(posedge clk); #1; if (rvalid4) seen++;
    rstn4 = 1'b0;
    @(negedge clk); @(negedge clk);
    rstn4 = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      if (rvalid4) seen++;
    end
    total++;
    if (seen !== 0) $display("FAIL reset_mid_rvalid: got %0d pulses, required 0", seen); else passed++;
    model(4, 1'b0, 32'h2020, 2'd2, 32'd0, erd, eer);
    txn(4, 1'b0, 32'h2020, 2'd2, 32'd0, rd, er, lat, busy);
    total++;
    if ({er, rd} !== {1'b0, erd}) $display("FAIL reset_mid_ram: got err=%b rdata=%h, required 0/%h", er, rd, erd); else passed++;
  endtask

  task automatic test_random();
    logic [31:0] rd, erd, adr, v;
    logic er, eer, wr;
    logic [1:0] nsz;
    int lat, busy, d, r;
    for (int k = 0; k < 80; k++) begin
      d   = ($urandom_range(0, 1) == 0) ? 1 : 4;
      wr  = 1'($urandom_range(0, 1));
      nsz = 2'($urandom_range(0, 3));
      r   = $urandom_range(0, 9);
      case (r)
        0:       adr = BASE - 32'($urandom_range(1, 8));
        1:       adr = 32'h6000 + 32'($urandom_range(0, 8));
        2:       adr = 32'h5FF0 + 32'($urandom_range(0, 15));
        default: adr = BASE + 32'($urandom_range(0, 255));
      endcase
      v = $urandom;
      model(d, wr, adr, nsz, v, erd, eer);
      txn(d, wr, adr, nsz, v, rd, er, lat, busy);
      total++;
      if ({er, rd} !== {eer, erd})
        $display("FAIL random_%0d L=%0d w=%b a=%h n=%0d: got err=%b rdata=%h, required err=%b rdata=%h",
                 k, d, wr, adr, nsz, er, rd, eer, erd);
      else passed++;
      total++;
      if (lat !== d) $display("FAIL random_latency_%0d: got %0d, required %0d", k, lat, d); else passed++;
    end
  endtask

`ifdef DMEM_STATS_EN
  task automatic test_stats();
    logic [31:0] rd;
    logic er;
    int lat, busy, n;
    @(negedge clk); clr1 = 1'b1;
    @(negedge clk); clr1 = 1'b0;
    for (int i = 0; i < 3; i++) txn(1, 1'b0, 32'h2000, 2'd2, 32'd0, rd, er, lat, busy);
    for (int i = 0; i < 2; i++) txn(1, 1'b1, 32'h2004, 2'd2, 32'h0101_0101 * 32'(i), rd, er, lat, busy);
    model(1, 1'b1, 32'h2004, 2'd2, 32'h0101_0101, rd, er);
    txn(1, 1'b0, 32'h2000, 2'd3, 32'd0, rd, er, lat, busy);
    total++;
    if ({sl1, ss1, se1} !== {32'd3, 32'd2, 32'd1})
      $display("FAIL stats_counts: got %0d/%0d/%0d, required 3/2/1", sl1, ss1, se1);
    else passed++;
    @(negedge clk);
    w = 1'b0; a = 32'h2000; nb = 2'd2; req1 = 1'b1;
    n = 0;
    while (!ready1 && n < 50) begin @(negedge clk); n++; end
    @(posedge clk);
    @(negedge clk); req1 = 1'b0; clr1 = 1'b1;
    @(posedge clk); #1;
    total++;
    if ({rvalid1, sl1, ss1, se1} !== {1'b1, 96'd0})
      $display("FAIL stats_clr_priority: got rvalid=%b %0d/%0d/%0d, required 1 0/0/0", rvalid1, sl1, ss1, se1);
    else passed++;
    @(negedge clk); clr1 = 1'b0;
  endtask
`endif

  initial begin
    test_reset();
    test_init();
    test_word();
    test_lanes();
    test_errors();
    test_latency();
    test_back_to_back();
    test_reset_mid();
    test_random();
`ifdef DMEM_STATS_EN
    test_stats();
`endif
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
